// File: rtl/lsu_mem_port_if.sv
// Core-side request/response and req/gnt/rvalid data-bus signals of the load/store unit.
// The master modport is the LSU view, the slave modport is the core+memory environment view.
interface lsu_mem_port_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req_valid;
  logic          req_we;
  logic [2:0]    req_func3;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          stall;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic [1:0]    resp_err_code;
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [3:0]    bus_be;
  logic [DW-1:0] bus_wdata;
  logic          bus_gnt;
  logic          bus_rvalid;
  logic [DW-1:0] bus_rdata;

  modport master (
    input  req_valid, req_we, req_func3, req_addr, req_wdata,
    output stall, resp_valid, resp_rdata, resp_err, resp_err_code,
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    output req_valid, req_we, req_func3, req_addr, req_wdata,
    input  stall, resp_valid, resp_rdata, resp_err, resp_err_code,
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/lsu_mem_port.sv
// Load/store unit: one request at a time over a req/gnt/rvalid bus, with byte lanes,
// load extension, and misaligned / illegal-width / timeout error reporting.
module lsu_mem_port #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input logic          clk,
  input logic          rst,
  lsu_mem_port_if.master io
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  // Counter may step once past TIMEOUT-1 when a grant lands exactly on expiry.
  localparam int CW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic          we_q, we_d;
  logic [2:0]    func3_q, func3_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    code_q, code_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          req_legal, req_misal;
  logic [DW-1:0] lane_word, load_ext;
  logic [3:0]    be_w;
  logic [DW-1:0] wdata_w;
  logic          in_addr, expired;

  always_comb begin
    req_legal = io.req_we ? (io.req_func3 inside {3'd0, 3'd1, 3'd2})
                          : (io.req_func3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    case (io.req_func3[1:0])
      2'd1:    req_misal = io.req_addr[0];
      2'd2:    req_misal = |io.req_addr[1:0];
      default: req_misal = 1'b0;
    endcase
  end

  always_comb begin
    lane_word = io.bus_rdata >> {addr_q[1:0], 3'b000};
    case (func3_q)
      3'd0:    load_ext = {{24{lane_word[7]}}, lane_word[7:0]};
      3'd1:    load_ext = {{16{lane_word[15]}}, lane_word[15:0]};
      3'd4:    load_ext = {24'd0, lane_word[7:0]};
      3'd5:    load_ext = {16'd0, lane_word[15:0]};
      default: load_ext = io.bus_rdata;
    endcase
  end

  always_comb begin
    case (func3_q[1:0])
      2'd0: begin
        be_w    = 4'b0001 << addr_q[1:0];
        wdata_w = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        be_w    = 4'b0011 << addr_q[1:0];
        wdata_w = {2{wdata_q[15:0]}};
      end
      default: begin
        be_w    = 4'b1111;
        wdata_w = wdata_q;
      end
    endcase
  end

  assign expired = (cnt_q >= CNT_LAST);

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    func3_d = func3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (io.req_valid) begin
          we_d    = io.req_we;
          func3_d = io.req_func3;
          addr_d  = io.req_addr;
          wdata_d = io.req_wdata;
          rdata_d = '0;
          cnt_d   = '0;
          // Legality is judged before alignment.
          if (!req_legal) begin
            code_d  = 2'b10;
            state_d = S_RESP;
          end else if (req_misal) begin
            code_d  = 2'b01;
            state_d = S_RESP;
          end else begin
            code_d  = 2'b00;
            state_d = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        cnt_d = cnt_q + 1'b1;
        if (io.bus_gnt) begin
          state_d = S_WAIT;
        end else if (expired) begin
          code_d  = 2'b11;
          state_d = S_RESP;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (io.bus_rvalid) begin
          if (!we_q) rdata_d = load_ext;
          state_d = S_RESP;
        end else if (expired) begin
          code_d  = 2'b11;
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      func3_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      code_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      func3_q <= func3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_addr          = (state_q == S_ADDR);
  assign io.stall         = (state_q == S_IDLE && io.req_valid) || in_addr || (state_q == S_WAIT);
  assign io.resp_valid    = (state_q == S_RESP);
  assign io.resp_err_code = io.resp_valid ? code_q : 2'b00;
  assign io.resp_err      = io.resp_valid && (code_q != 2'b00);
  assign io.resp_rdata    = io.resp_valid ? rdata_q : '0;
  assign io.bus_req       = in_addr;
  assign io.bus_we        = in_addr && we_q;
  assign io.bus_addr      = in_addr ? {addr_q[AW-1:2], 2'b00} : '0;
  assign io.bus_be        = in_addr ? be_w : 4'b0000;
  assign io.bus_wdata     = in_addr ? wdata_w : '0;
endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: fixed vector table, hand-written reset sequence and
// randomized transactions checked against a cycle-count/arithmetic reference model.
module tb_lsu_mem_port;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_mem_port_if #(.AW(32), .DW(32)) ifc();
  lsu_mem_port #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .io(ifc));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          g;
    int          rv;
    logic [31:0] rdata;
    bit          noise;
    logic [31:0] e_rdata;
    logic [1:0]  e_code;
    int          e_lat;
    int          e_reqs;
    logic [31:0] e_baddr;
    logic [3:0]  e_be;
    logic [31:0] e_bwdata;
  } vec_t;

  typedef struct {
    int          lat;
    int          reqs;
    int          stalls;
    logic [31:0] rdata;
    logic [1:0]  code;
    logic        err;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    logic [3:0]  be;
    logic        bwe;
    bit          stable;
    bit          stall_in_resp;
    bit          after_valid;
    bit          timed_out;
  } obs_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " resp_valid"}, 32'(ifc.resp_valid), 32'd0);
    chk({tag, " stall"}, 32'(ifc.stall), 32'd0);
    chk({tag, " bus_req"}, 32'(ifc.bus_req), 32'd0);
    chk({tag, " bus_we"}, 32'(ifc.bus_we), 32'd0);
    chk({tag, " bus_addr"}, ifc.bus_addr, 32'd0);
    chk({tag, " bus_be"}, 32'(ifc.bus_be), 32'd0);
    chk({tag, " bus_wdata"}, ifc.bus_wdata, 32'd0);
    chk({tag, " resp_rdata"}, ifc.resp_rdata, 32'd0);
    chk({tag, " resp_err"}, 32'(ifc.resp_err), 32'd0);
    chk({tag, " resp_err_code"}, 32'(ifc.resp_err_code), 32'd0);
  endtask

  // Reference: legality, alignment, lanes and latency from the access rules.
  // g = ADDR cycles before grant (-1 never), rv = WAIT cycles before rvalid (-1 never).
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input int g, input int rv,
                                input logic [31:0] rdata, output logic [31:0] e_rdata,
                                output logic [1:0] e_code, output int e_lat, output int e_reqs,
                                output logic [3:0] e_be, output logic [31:0] e_bwdata);
    int size, r, expiry;
    bit legal;
    logic [31:0] sh;
    e_rdata = 0; e_reqs = 0; e_be = 0; e_bwdata = 0; e_code = 0; e_lat = 1;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    size  = (f3 == 3'd0 || f3 == 3'd4) ? 1 : ((f3 == 3'd1 || f3 == 3'd5) ? 2 : 4);
    if (!legal) begin e_code = 2'b10; return; end
    if ((addr % size) != 0) begin e_code = 2'b01; return; end
    e_be     = (size == 4) ? 4'hF : 4'(((1 << size) - 1) << addr[1:0]);
    e_bwdata = (size == 1) ? {4{wdata[7:0]}} : ((size == 2) ? {2{wdata[15:0]}} : wdata);
    if (g < 0 || g >= TO) begin
      e_code = 2'b11; e_lat = 1 + TO; e_reqs = TO; return;
    end
    e_reqs = g + 1;
    r      = g + 1 + rv;
    expiry = (TO - 1 > g + 1) ? TO - 1 : g + 1;
    if (rv < 0 || r > expiry) begin
      e_code = 2'b11; e_lat = 2 + expiry; return;
    end
    e_lat = 2 + r;
    if (!we) begin
      sh = rdata >> (8 * addr[1:0]);
      case (f3)
        3'd0:    e_rdata = {{24{sh[7]}}, sh[7:0]};
        3'd1:    e_rdata = {{16{sh[15]}}, sh[15:0]};
        3'd4:    e_rdata = {24'd0, sh[7:0]};
        3'd5:    e_rdata = {16'd0, sh[15:0]};
        default: e_rdata = rdata;
      endcase
    end
  endfunction

  // Plays the core and the memory for one request; cycle 0 is the request cycle.
  task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input int g, input int rv,
                            input logic [31:0] rdata, input bit noise, output obs_t o);
    int c, reqs, waitc;
    bit granted, done;
    o = '{default: 0};
    o.stable = 1;
    @(negedge clk);
    ifc.req_valid = 1'b1; ifc.req_we = we; ifc.req_func3 = f3;
    ifc.req_addr = addr; ifc.req_wdata = wdata;
    ifc.bus_gnt = 1'b0; ifc.bus_rvalid = 1'b0; ifc.bus_rdata = rdata;
    c = 0; reqs = 0; waitc = 0; granted = 0; done = 0;
    while (!done) begin
      #1;
      ifc.bus_gnt = 1'b0;
      ifc.bus_rvalid = 1'b0;
      if (ifc.resp_valid) begin
        o.lat = c; o.rdata = ifc.resp_rdata; o.code = ifc.resp_err_code;
        o.err = ifc.resp_err; o.stall_in_resp = ifc.stall;
        ifc.req_valid = 1'b0;
        done = 1;
      end else if (c > 60) begin
        o.timed_out = 1; o.lat = c;
        ifc.req_valid = 1'b0;
        done = 1;
      end else begin
        if (ifc.stall) o.stalls++;
        if (ifc.bus_req) begin
          reqs++;
          if (reqs == 1) begin
            o.baddr = ifc.bus_addr; o.be = ifc.bus_be;
            o.bwdata = ifc.bus_wdata; o.bwe = ifc.bus_we;
          end else if (o.baddr !== ifc.bus_addr || o.be !== ifc.bus_be ||
                       o.bwdata !== ifc.bus_wdata || o.bwe !== ifc.bus_we) begin
            o.stable = 0;
          end
          ifc.bus_rvalid = noise;
          if (g >= 0 && reqs - 1 == g) begin
            ifc.bus_gnt = 1'b1;
            granted = 1;
          end
        end else if (granted) begin
          if (rv >= 0 && waitc == rv) ifc.bus_rvalid = 1'b1;
          waitc++;
        end
        @(negedge clk);
        c++;
      end
    end
    o.reqs = reqs;
    @(negedge clk);
    #1;
    o.after_valid = ifc.resp_valid;
  endtask

  task automatic check_obs(input string tag, input logic we, input obs_t o,
                           input logic [31:0] e_rdata, input logic [1:0] e_code, input int e_lat,
                           input int e_reqs, input logic [31:0] e_baddr, input logic [3:0] e_be,
                           input logic [31:0] e_bwdata);
    chk({tag, " no_hang"}, 32'(o.timed_out), 32'd0);
    chk({tag, " latency"}, 32'(o.lat), 32'(e_lat));
    chk({tag, " rdata"}, o.rdata, e_rdata);
    chk({tag, " err_code"}, 32'(o.code), 32'(e_code));
    chk({tag, " err"}, 32'(o.err), 32'(e_code != 2'b00));
    chk({tag, " bus_req_cycles"}, 32'(o.reqs), 32'(e_reqs));
    chk({tag, " stall_cycles"}, 32'(o.stalls), 32'(e_lat));
    chk({tag, " stall_in_resp"}, 32'(o.stall_in_resp), 32'd0);
    chk({tag, " single_pulse"}, 32'(o.after_valid), 32'd0);
    if (e_reqs > 0) begin
      chk({tag, " bus_addr"}, o.baddr, e_baddr);
      chk({tag, " bus_be"}, 32'(o.be), 32'(e_be));
      chk({tag, " bus_we"}, 32'(o.bwe), 32'(we));
      chk({tag, " bus_stable"}, 32'(o.stable), 32'd1);
      if (we) chk({tag, " bus_wdata"}, o.bwdata, e_bwdata);
    end
    $display("txn %s we=%0d lat=%0d code=%0d rdata=%h", tag, we, o.lat, o.code, o.rdata);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[17];
    obs_t o;
    logic [31:0] e_rdata, e_bwdata, addr, wdata, rdata;
    logic [1:0]  e_code;
    logic [3:0]  e_be;
    logic [2:0]  f3;
    logic        we;
    int          e_lat, e_reqs, g, rv;

    //          we    f3    addr          wdata         g   rv  rdata         nz  e_rdata       code  lat reqs baddr        be     bwdata
    vecs[0]  = '{1'b0, 3'd2, 32'h0000_0100, 32'h0,        0,  0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 2'd0, 3,  1, 32'h0000_0100, 4'hF, 32'h0};
    vecs[1]  = '{1'b0, 3'd0, 32'h0000_0203, 32'h0,        0,  0, 32'h80FF0000, 0, 32'hFFFFFF80, 2'd0, 3,  1, 32'h0000_0200, 4'h8, 32'h0};
    vecs[2]  = '{1'b0, 3'd4, 32'h0000_0203, 32'h0,        0,  0, 32'h80FF0000, 0, 32'h00000080, 2'd0, 3,  1, 32'h0000_0200, 4'h8, 32'h0};
    vecs[3]  = '{1'b1, 3'd1, 32'h0000_0302, 32'h1234ABCD, 3,  0, 32'h55555555, 0, 32'h0,        2'd0, 6,  4, 32'h0000_0300, 4'hC, 32'hABCDABCD};
    vecs[4]  = '{1'b0, 3'd2, 32'h0000_0101, 32'h0,        0,  0, 32'h11111111, 0, 32'h0,        2'd1, 1,  0, 32'h0,         4'h0, 32'h0};
    vecs[5]  = '{1'b0, 3'd3, 32'h0000_0100, 32'h0,        0,  0, 32'h11111111, 0, 32'h0,        2'd2, 1,  0, 32'h0,         4'h0, 32'h0};
    vecs[6]  = '{1'b0, 3'd2, 32'h0000_0500, 32'h0,        0, -1, 32'h22222222, 0, 32'h0,        2'd3, 17, 1, 32'h0000_0500, 4'hF, 32'h0};
    vecs[7]  = '{1'b0, 3'd5, 32'h0000_0602, 32'h0,        0,  0, 32'h80011234, 0, 32'h00008001, 2'd0, 3,  1, 32'h0000_0600, 4'hC, 32'h0};
    vecs[8]  = '{1'b0, 3'd1, 32'h0000_0602, 32'h0,        0,  0, 32'h80011234, 0, 32'hFFFF8001, 2'd0, 3,  1, 32'h0000_0600, 4'hC, 32'h0};
    vecs[9]  = '{1'b1, 3'd0, 32'h0000_0703, 32'h000000A5, 1,  2, 32'h0,        0, 32'h0,        2'd0, 6,  2, 32'h0000_0700, 4'h8, 32'hA5A5A5A5};
    vecs[10] = '{1'b1, 3'd2, 32'h0000_0800, 32'hCAFEF00D, 0,  1, 32'h0,        1, 32'h0,        2'd0, 4,  1, 32'h0000_0800, 4'hF, 32'hCAFEF00D};
    vecs[11] = '{1'b1, 3'd4, 32'h0000_0800, 32'h12345678, 0,  0, 32'h0,        0, 32'h0,        2'd2, 1,  0, 32'h0,         4'h0, 32'h0};
    vecs[12] = '{1'b0, 3'd1, 32'h0000_0603, 32'h0,        0,  0, 32'h0,        0, 32'h0,        2'd1, 1,  0, 32'h0,         4'h0, 32'h0};
    vecs[13] = '{1'b0, 3'd2, 32'h0000_0900, 32'h0,        0, 14, 32'h13572468, 1, 32'h13572468, 2'd0, 17, 1, 32'h0000_0900, 4'hF, 32'h0};
    vecs[14] = '{1'b0, 3'd2, 32'h0000_0900, 32'h0,        0, 15, 32'h13572468, 0, 32'h0,        2'd3, 17, 1, 32'h0000_0900, 4'hF, 32'h0};
    vecs[15] = '{1'b0, 3'd2, 32'h0000_0A00, 32'h0,       -1,  0, 32'h0,        1, 32'h0,        2'd3, 17, 16, 32'h0000_0A00, 4'hF, 32'h0};
    vecs[16] = '{1'b0, 3'd3, 32'h0000_0101, 32'h0,        0,  0, 32'h0,        0, 32'h0,        2'd2, 1,  0, 32'h0,         4'h0, 32'h0};

    rst = 1'b1;
    ifc.req_valid = 1'b0; ifc.req_we = 1'b0; ifc.req_func3 = 3'd0;
    ifc.req_addr = 32'h0; ifc.req_wdata = 32'h0;
    ifc.bus_gnt = 1'b0; ifc.bus_rvalid = 1'b0; ifc.bus_rdata = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    chk_quiet("reset");
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_access(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].g, vecs[i].rv,
                 vecs[i].rdata, vecs[i].noise, o);
      check_obs($sformatf("vec%0d", i), vecs[i].we, o, vecs[i].e_rdata, vecs[i].e_code,
                vecs[i].e_lat, vecs[i].e_reqs, vecs[i].e_baddr, vecs[i].e_be, vecs[i].e_bwdata);
    end

    // Reset while waiting for rvalid, then a late rvalid must be ignored.
    @(negedge clk);
    ifc.req_valid = 1'b1; ifc.req_we = 1'b0; ifc.req_func3 = 3'd2;
    ifc.req_addr = 32'h0000_0400; ifc.bus_rdata = 32'hBADC0FFE;
    @(negedge clk);
    #1;
    chk("rstwait bus_req", 32'(ifc.bus_req), 32'd1);
    ifc.bus_gnt = 1'b1;
    @(negedge clk);
    ifc.bus_gnt = 1'b0;
    #1;
    chk("rstwait in_wait stall", 32'(ifc.stall), 32'd1);
    rst = 1'b1; ifc.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0; ifc.bus_rvalid = 1'b1;
    #1;
    chk_quiet("after_rst");
    @(negedge clk);
    ifc.bus_rvalid = 1'b0;
    #1;
    chk_quiet("late_rvalid");
    $display("txn rst_in_wait done");
    run_access(1'b0, 3'd2, 32'h0000_0404, 32'h0, 0, 0, 32'h0BADF00D, 1'b0, o);
    check_obs("post_rst_lw", 1'b0, o, 32'h0BADF00D, 2'd0, 3, 1, 32'h0000_0404, 4'hF, 32'h0);

    for (int i = 0; i < 60; i++) begin
      we    = 1'($urandom_range(0, 1));
      f3    = 3'($urandom_range(0, 7));
      addr  = {16'h0, 4'($urandom_range(0, 15)), 10'($urandom), 2'($urandom_range(0, 3))};
      wdata = $urandom;
      rdata = $urandom;
      g     = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4));
      case ($urandom_range(0, 7))
        0:       rv = -1;
        1:       rv = int'($urandom_range(12, 16));
        default: rv = int'($urandom_range(0, 5));
      endcase
      model(we, f3, addr, wdata, g, rv, rdata, e_rdata, e_code, e_lat, e_reqs, e_be, e_bwdata);
      run_access(we, f3, addr, wdata, g, rv, rdata, 1'($urandom_range(0, 1)), o);
      check_obs($sformatf("rnd%0d", i), we, o, e_rdata, e_code, e_lat, e_reqs,
                addr & 32'hFFFF_FFFC, e_be, e_bwdata);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
